// File: rtl/tile_pkg.sv
// ---------------------------------------------------------------------------
// tile_pkg
// Shared definitions for the tile blitter: bytes per pixel, the packed
// {R,G,B} pixel type, the blitter FSM state type and the helper that turns
// a source (row, column) into a byte offset inside the tile.
// ---------------------------------------------------------------------------
package tile_pkg;

   localparam int BYTES_PER_PIXEL = 3;

   typedef logic [23:0] rgb_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_WAIT  = 3'd2,
      ST_EMIT  = 3'd3,
      ST_DONE  = 3'd4
   } blit_state_t;

   // Byte offset of the R byte of source pixel (sr, sc) in a row-major tile.
   function automatic int pixel_offset(input int sr, input int sc, input int tile_w);
      return BYTES_PER_PIXEL * (sr * tile_w + sc);
   endfunction

endpackage

// File: rtl/tile_rom_fetch.sv
// ---------------------------------------------------------------------------
// tile_rom_fetch
// Issues the three byte addresses of one pixel on consecutive cycles and
// captures the returning R, G, B bytes ROM_LATENCY cycles later.
// Ports:
//   i_clk, i_reset   clock, synchronous active-high reset
//   i_go             one-cycle request; i_addr is the R byte address
//   o_rom_addr       registered ROM read address
//   i_rom_data       ROM read data
//   o_rgb            {R,G,B}; B comes straight from i_rom_data
//   o_rgb_valid      high in the cycle the B byte is on i_rom_data
// ---------------------------------------------------------------------------
module tile_rom_fetch
   import tile_pkg::*;
#(
   parameter int ADDR_W      = 12,
   parameter int ROM_LATENCY = 2
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_go,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [ADDR_W-1:0] o_rom_addr,
   input  logic [7:0]        i_rom_data,
   output rgb_t              o_rgb,
   output logic              o_rgb_valid
);

   logic [ADDR_W-1:0]      r_rom_addr;
   logic                   r_issue;
   logic [1:0]             r_k;
   logic [ROM_LATENCY-1:0] r_sr_vld;
   logic [1:0]             r_sr_k [ROM_LATENCY];
   logic [7:0]             r_red;
   logic [7:0]             r_grn;

   // Address sequencing, byte-tag delay line and R/G capture.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_rom_addr <= {ADDR_W{1'b0}};
         r_issue    <= 1'b0;
         r_k        <= 2'd0;
         r_sr_vld   <= {ROM_LATENCY{1'b0}};
         r_red      <= 8'd0;
         r_grn      <= 8'd0;
         for (int i = 0; i < ROM_LATENCY; i++) begin
            r_sr_k[i] <= 2'd0;
         end
      end else begin
         if (i_go) begin
            r_rom_addr <= i_addr;
            r_issue    <= 1'b1;
            r_k        <= 2'd0;
         end else if (r_issue) begin
            if (r_k == 2'd2) begin
               r_issue <= 1'b0;
            end else begin
               r_rom_addr <= r_rom_addr + ADDR_W'(1);
               r_k        <= r_k + 2'd1;
            end
         end
         // Each presented address is tagged with its byte index; the tag
         // reaches the last stage exactly when its data is on i_rom_data.
         r_sr_vld[0] <= r_issue;
         r_sr_k[0]   <= r_k;
         for (int i = 1; i < ROM_LATENCY; i++) begin
            r_sr_vld[i] <= r_sr_vld[i-1];
            r_sr_k[i]   <= r_sr_k[i-1];
         end
         if (r_sr_vld[ROM_LATENCY-1]) begin
            case (r_sr_k[ROM_LATENCY-1])
               2'd0:    r_red <= i_rom_data;
               2'd1:    r_grn <= i_rom_data;
               default: ;
            endcase
         end
      end
   end

   assign o_rom_addr  = r_rom_addr;
   assign o_rgb       = {r_red, r_grn, i_rom_data};
   assign o_rgb_valid = r_sr_vld[ROM_LATENCY-1] & (r_sr_k[ROM_LATENCY-1] == 2'd2);

endmodule

// File: rtl/tile_blitter.sv
// ---------------------------------------------------------------------------
// tile_blitter
// Streams one TILE_W x TILE_H tile from byte-wide ROM (3 bytes per pixel,
// row-major) to a valid/ready pixel port, with optional mirroring and
// colour-key transparency.
// Ports:
//   i_clk, i_reset                  clock, synchronous active-high reset
//   i_start                         begin a tile (taken only in IDLE)
//   i_tile_base, i_x_pos, i_y_pos   ROM base and screen origin, latched on start
//   i_flip_x, i_flip_y, i_key_rgb   mirroring and transparency colour, latched
//   o_busy, o_done                  tile in progress / one-cycle completion pulse
//   o_rom_addr, i_rom_data          ROM read port
//   o_pix_valid, i_pix_ready        pixel handshake
//   o_pix_x, o_pix_y, o_pix_rgb     pixel payload
// ---------------------------------------------------------------------------
module tile_blitter
   import tile_pkg::*;
#(
   parameter int TILE_W      = 8,
   parameter int TILE_H      = 8,
   parameter int ADDR_W      = 12,
   parameter int COORD_W     = 8,
   parameter int ROM_LATENCY = 2,
   parameter int KEY_EN      = 1
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_start,
   input  logic [ADDR_W-1:0]  i_tile_base,
   input  logic [COORD_W-1:0] i_x_pos,
   input  logic [COORD_W-1:0] i_y_pos,
   input  logic               i_flip_x,
   input  logic               i_flip_y,
   input  logic [23:0]        i_key_rgb,
   output logic               o_busy,
   output logic               o_done,
   output logic [ADDR_W-1:0]  o_rom_addr,
   input  logic [7:0]         i_rom_data,
   output logic               o_pix_valid,
   input  logic               i_pix_ready,
   output logic [COORD_W-1:0] o_pix_x,
   output logic [COORD_W-1:0] o_pix_y,
   output logic [23:0]        o_pix_rgb
);

   localparam int CW = $clog2(TILE_W + 1);
   localparam int RW = $clog2(TILE_H + 1);
   localparam logic [CW-1:0] LAST_C = CW'(TILE_W - 1);
   localparam logic [RW-1:0] LAST_R = RW'(TILE_H - 1);

   blit_state_t        r_state;
   logic [1:0]         r_fcnt;
   logic [CW-1:0]      r_c;
   logic [RW-1:0]      r_r;
   logic [ADDR_W-1:0]  r_base;
   logic [COORD_W-1:0] r_x_pos;
   logic [COORD_W-1:0] r_y_pos;
   logic               r_flip_x;
   logic               r_flip_y;
   rgb_t               r_key;

   logic [CW-1:0]      w_nxt_c;
   logic [RW-1:0]      w_nxt_r;
   logic [CW-1:0]      w_ld_c;
   logic [RW-1:0]      w_ld_r;
   logic [ADDR_W-1:0]  w_ld_base;
   logic               w_ld_fx;
   logic               w_ld_fy;
   int                 w_src_c;
   int                 w_src_r;
   logic [ADDR_W-1:0]  w_addr;
   logic               w_last;
   logic               w_accept;
   logic               w_advance;
   logic               w_key_hit;
   logic               w_go;
   rgb_t               w_rgb;
   logic               w_rgb_valid;

   tile_rom_fetch #(
      .ADDR_W      (ADDR_W),
      .ROM_LATENCY (ROM_LATENCY)
   ) u_fetch (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_go        (w_go),
      .i_addr      (w_addr),
      .o_rom_addr  (o_rom_addr),
      .i_rom_data  (i_rom_data),
      .o_rgb       (w_rgb),
      .o_rgb_valid (w_rgb_valid)
   );

   // Next-pixel selection and its ROM address; a new fetch is launched on the
   // same edge that accepts start or retires the current pixel, so fetching
   // restarts without an idle cycle.
   always_comb begin
      w_last    = (r_c == LAST_C) && (r_r == LAST_R);
      w_nxt_c   = (r_c == LAST_C) ? {CW{1'b0}} : r_c + CW'(1);
      w_nxt_r   = (r_c == LAST_C) ? r_r + RW'(1) : r_r;
      w_key_hit = (KEY_EN != 0) && (w_rgb == r_key);
      w_accept  = (r_state == ST_IDLE) && i_start;
      w_advance = ((r_state == ST_EMIT) && i_pix_ready) ||
                  ((r_state == ST_WAIT) && w_rgb_valid && w_key_hit);
      if (w_accept) begin
         w_ld_c    = {CW{1'b0}};
         w_ld_r    = {RW{1'b0}};
         w_ld_base = i_tile_base;
         w_ld_fx   = i_flip_x;
         w_ld_fy   = i_flip_y;
      end else begin
         w_ld_c    = w_nxt_c;
         w_ld_r    = w_nxt_r;
         w_ld_base = r_base;
         w_ld_fx   = r_flip_x;
         w_ld_fy   = r_flip_y;
      end
      if (w_ld_fx) begin
         w_src_c = TILE_W - 1 - int'(w_ld_c);
      end else begin
         w_src_c = int'(w_ld_c);
      end
      if (w_ld_fy) begin
         w_src_r = TILE_H - 1 - int'(w_ld_r);
      end else begin
         w_src_r = int'(w_ld_r);
      end
      w_addr = w_ld_base + ADDR_W'(pixel_offset(w_src_r, w_src_c, TILE_W));
      w_go   = w_accept || (w_advance && !w_last);
   end

   // Blitter FSM with registered status and pixel outputs.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= ST_IDLE;
         r_fcnt      <= 2'd0;
         r_c         <= {CW{1'b0}};
         r_r         <= {RW{1'b0}};
         r_base      <= {ADDR_W{1'b0}};
         r_x_pos     <= {COORD_W{1'b0}};
         r_y_pos     <= {COORD_W{1'b0}};
         r_flip_x    <= 1'b0;
         r_flip_y    <= 1'b0;
         r_key       <= 24'd0;
         o_busy      <= 1'b0;
         o_done      <= 1'b0;
         o_pix_valid <= 1'b0;
         o_pix_x     <= {COORD_W{1'b0}};
         o_pix_y     <= {COORD_W{1'b0}};
         o_pix_rgb   <= 24'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               o_done <= 1'b0;
               if (i_start) begin
                  r_base   <= i_tile_base;
                  r_x_pos  <= i_x_pos;
                  r_y_pos  <= i_y_pos;
                  r_flip_x <= i_flip_x;
                  r_flip_y <= i_flip_y;
                  r_key    <= i_key_rgb;
                  r_c      <= {CW{1'b0}};
                  r_r      <= {RW{1'b0}};
                  r_fcnt   <= 2'd0;
                  o_busy   <= 1'b1;
                  r_state  <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               if (r_fcnt == 2'd2) begin
                  r_fcnt  <= 2'd0;
                  r_state <= ST_WAIT;
               end else begin
                  r_fcnt <= r_fcnt + 2'd1;
               end
            end
            ST_WAIT: begin
               if (w_rgb_valid) begin
                  if (w_key_hit) begin
                     // Transparent pixel: retire it without a handshake.
                     if (w_last) begin
                        o_done  <= 1'b1;
                        o_busy  <= 1'b0;
                        r_state <= ST_DONE;
                     end else begin
                        r_c     <= w_nxt_c;
                        r_r     <= w_nxt_r;
                        r_state <= ST_FETCH;
                     end
                  end else begin
                     o_pix_valid <= 1'b1;
                     o_pix_x     <= r_x_pos + COORD_W'(r_c);
                     o_pix_y     <= r_y_pos + COORD_W'(r_r);
                     o_pix_rgb   <= w_rgb;
                     r_state     <= ST_EMIT;
                  end
               end
            end
            ST_EMIT: begin
               if (i_pix_ready) begin
                  o_pix_valid <= 1'b0;
                  if (w_last) begin
                     o_done  <= 1'b1;
                     o_busy  <= 1'b0;
                     r_state <= ST_DONE;
                  end else begin
                     r_c     <= w_nxt_c;
                     r_r     <= w_nxt_r;
                     r_state <= ST_FETCH;
                  end
               end
            end
            ST_DONE: begin
               o_done  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tile_blitter.sv
module tb_tile_blitter;

   typedef struct packed {
      logic [7:0]  x;
      logic [7:0]  y;
      logic [23:0] rgb;
   } pix_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [11:0] tile_base;
   logic [7:0]  x_pos;
   logic [7:0]  y_pos;
   logic        flip_x;
   logic        flip_y;
   logic [23:0] key_rgb;
   logic        busy;
   logic        done;
   logic [11:0] rom_addr;
   logic [7:0]  rom_data;
   logic        pix_valid;
   logic        pix_ready;
   logic [7:0]  pix_x;
   logic [7:0]  pix_y;
   logic [23:0] pix_rgb;

   logic [7:0]  mem [4096];
   logic [7:0]  rom_p1;

   int   total = 0;
   int   bad = 0;
   int   hs_cnt = 0;
   int   done_cnt = 0;
   pix_t exp_q[$];
   pix_t got_q[$];

   always #5 clk = ~clk;

   tile_blitter dut (
      .i_clk       (clk),
      .i_reset     (reset),
      .i_start     (start),
      .i_tile_base (tile_base),
      .i_x_pos     (x_pos),
      .i_y_pos     (y_pos),
      .i_flip_x    (flip_x),
      .i_flip_y    (flip_y),
      .i_key_rgb   (key_rgb),
      .o_busy      (busy),
      .o_done      (done),
      .o_rom_addr  (rom_addr),
      .i_rom_data  (rom_data),
      .o_pix_valid (pix_valid),
      .i_pix_ready (pix_ready),
      .o_pix_x     (pix_x),
      .o_pix_y     (pix_y),
      .o_pix_rgb   (pix_rgb)
   );

   // ROM with two cycles from address to data.
   always @(posedge clk) begin
      rom_p1   <= mem[rom_addr];
      rom_data <= rom_p1;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Monitor: pops the scoreboard on every handshake, counts done pulses.
   always @(negedge clk) begin
      pix_t g;
      pix_t e;
      if (done) done_cnt++;
      if (pix_valid && pix_ready) begin
         g = {pix_x, pix_y, pix_rgb};
         hs_cnt++;
         got_q.push_back(g);
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_pixel: got %0h with nothing expected", g);
         end else begin
            e = exp_q.pop_front();
            check("pixel", 64'(g), 64'(e));
         end
      end
   end

   task automatic init_mem();
      for (int a = 0; a < 4096; a++) mem[a] = a[7:0];
   endtask

   // Expected pixel stream for a tile, in screen order.
   task automatic build_expected(input logic [11:0] base, input logic [7:0] x, input logic [7:0] y,
                                 input logic fx, input logic fy, input logic [23:0] key);
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < 8; c++) begin
            int          sc;
            int          sr;
            logic [11:0] a;
            logic [23:0] rgb;
            pix_t        p;
            sc  = fx ? 7 - c : c;
            sr  = fy ? 7 - r : r;
            a   = base + 12'(3 * (sr * 8 + sc));
            rgb = {mem[a], mem[12'(a + 12'd1)], mem[12'(a + 12'd2)]};
            if (rgb != key) begin
               p = {8'(x + 8'(c)), 8'(y + 8'(r)), rgb};
               exp_q.push_back(p);
            end
         end
      end
   endtask

   task automatic pulse_start(input logic [11:0] base, input logic [7:0] x, input logic [7:0] y,
                              input logic fx, input logic fy, input logic [23:0] key);
      tile_base = base; x_pos = x; y_pos = y; flip_x = fx; flip_y = fy; key_rgb = key;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_after_start", busy, 1'b1);
      // Scramble tile inputs: they must have been latched.
      tile_base = ~base; x_pos = ~x; y_pos = ~y; flip_x = ~fx; flip_y = ~fy; key_rgb = ~key;
   endtask

   // Run one tile to completion; stall_idx >= 0 holds pix_ready low 5 cycles on that pixel.
   task automatic run_tile(input logic [11:0] base, input logic [7:0] x, input logic [7:0] y,
                           input logic fx, input logic fy, input logic [23:0] key,
                           input int stall_idx, input int busy_start_at);
      int   d0;
      int   h0;
      bit   stalled;
      bit   finished;
      pix_t snap;
      d0 = done_cnt;
      h0 = hs_cnt;
      stalled = 1'b0;
      finished = 1'b0;
      got_q.delete();
      build_expected(base, x, y, fx, fy, key);
      pulse_start(base, x, y, fx, fy, key);
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(posedge clk); #1;
         start = (cyc == busy_start_at);
         if (done_cnt != d0) begin
            finished = 1'b1;
            break;
         end
         if (stall_idx >= 0 && !stalled && pix_valid && hs_cnt == h0 + stall_idx) begin
            pix_ready = 1'b0;
            snap = {pix_x, pix_y, pix_rgb};
            for (int s = 0; s < 5; s++) begin
               @(negedge clk);
               check("stall_valid", pix_valid, 1'b1);
               check("stall_data", 64'({pix_x, pix_y, pix_rgb}), 64'(snap));
               @(posedge clk); #1;
            end
            pix_ready = 1'b1;
            stalled = 1'b1;
         end
      end
      start = 1'b0;
      check("tile_finished", finished, 1'b1);
      check("busy_low_after_done", busy, 1'b0);
      check("done_single_cycle", done, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      check("done_count", 64'(done_cnt - d0), 64'd1);
      check("expected_drained", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
   endtask

   initial begin
      int   h0;
      int   d0;
      pix_t p;
      reset = 1'b1; start = 1'b0; tile_base = 12'd0; x_pos = 8'd0; y_pos = 8'd0;
      flip_x = 1'b0; flip_y = 1'b0; key_rgb = 24'd0; pix_ready = 1'b1;
      init_mem();
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_valid", pix_valid, 1'b0);
      check("rst_rom_addr", rom_addr, 12'h000);
      check("rst_pix", 64'({pix_x, pix_y, pix_rgb}), 64'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Test 1: plain tile.
      h0 = hs_cnt;
      run_tile(12'h010, 8'd10, 8'd20, 1'b0, 1'b0, 24'h000000, -1, -1);
      check("t1_handshakes", 64'(hs_cnt - h0), 64'd64);
      p = got_q[0];
      check("t1_first", 64'(p), 64'({8'd10, 8'd20, 24'h101112}));
      p = got_q[63];
      check("t1_last", 64'(p), 64'({8'd17, 8'd27, 24'hCDCECF}));

      // Test 2: both flips.
      run_tile(12'h010, 8'd10, 8'd20, 1'b1, 1'b1, 24'h000000, -1, -1);
      p = got_q[0];
      check("t2_first", 64'(p), 64'({8'd10, 8'd20, 24'hCDCECF}));
      p = got_q[63];
      check("t2_last", 64'(p), 64'({8'd17, 8'd27, 24'h101112}));

      // Test 3: ten black pixels are transparent.
      for (int a = 12'h200; a < 12'h21E; a++) mem[a] = 8'h00;
      h0 = hs_cnt;
      run_tile(12'h200, 8'd0, 8'd0, 1'b0, 1'b0, 24'h000000, -1, -1);
      check("t3_handshakes", 64'(hs_cnt - h0), 64'd54);
      p = got_q[0];
      check("t3_first", 64'(p), 64'({8'd2, 8'd1, 24'h1E1F20}));
      init_mem();

      // Test 4: backpressure on the third pixel.
      h0 = hs_cnt;
      run_tile(12'h040, 8'd30, 8'd40, 1'b0, 1'b0, 24'h000000, 2, -1);
      check("t4_handshakes", 64'(hs_cnt - h0), 64'd64);

      // Test 5: coordinate and ROM address wrap.
      run_tile(12'hFFE, 8'hFC, 8'h00, 1'b0, 1'b0, 24'h000000, -1, -1);
      p = got_q[0];
      check("t5_first", 64'(p), 64'({8'hFC, 8'h00, 24'hFEFF00}));
      p = got_q[3];
      check("t5_x3", p.x, 8'hFF);
      p = got_q[4];
      check("t5_x4", p.x, 8'h00);
      p = got_q[7];
      check("t5_x7", p.x, 8'h03);

      // Test 6: reset mid-tile, then a full tile with a start pulse while busy.
      d0 = done_cnt;
      build_expected(12'h080, 8'd50, 8'd60, 1'b0, 1'b0, 24'h000000);
      pulse_start(12'h080, 8'd50, 8'd60, 1'b0, 1'b0, 24'h000000);
      repeat (30) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      exp_q.delete();
      check("t6_rst_busy", busy, 1'b0);
      check("t6_rst_valid", pix_valid, 1'b0);
      check("t6_rst_rom_addr", rom_addr, 12'h000);
      check("t6_rst_pix", 64'({pix_x, pix_y, pix_rgb}), 64'd0);
      repeat (20) @(posedge clk);
      #1;
      check("t6_no_done_after_abort", 64'(done_cnt - d0), 64'd0);
      check("t6_idle_after_abort", busy, 1'b0);
      h0 = hs_cnt;
      run_tile(12'h010, 8'd10, 8'd20, 1'b0, 1'b0, 24'h000000, -1, 15);
      check("t6_handshakes", 64'(hs_cnt - h0), 64'd64);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
